// File: rtl/charlie_pkg.sv
// Shared types and helpers for the charlieplex LED scanner.
package charlie_pkg;

    typedef enum logic {
        DEAD  = 1'b0,
        DRIVE = 1'b1
    } state_e;

    // Flat LED index for anode r and cathode c (c != r).
    function automatic int unsigned led_index(input int unsigned r, input int unsigned c,
                                              input int unsigned pins);
        return r * (pins - 1) + ((c < r) ? c : c - 1);
    endfunction

endpackage

// File: rtl/charlie_framebuf.sv
// Double-buffered LED frame store: writes go to the back bank, the front bank is read combinationally.
module charlie_framebuf
    import charlie_pkg::*;
#(
    parameter int unsigned LEDS = 42,
    parameter int unsigned LW   = 1,
    parameter int unsigned AW   = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en_i,
    input  logic [AW-1:0]            wr_addr_i,
    input  logic [LW-1:0]            wr_data_i,
    input  logic                     swap_i,
    output logic [LEDS-1:0][LW-1:0]  front_o
);

    logic [1:0][LEDS-1:0][LW-1:0] bank_q, bank_d;
    logic                         sel_q, sel_d;

    // Out-of-range addresses are dropped; the front bank is never written.
    always_comb begin
        bank_d = bank_q;
        sel_d  = swap_i ? ~sel_q : sel_q;
        if (wr_en_i && (32'(wr_addr_i) < LEDS)) begin
            bank_d[~sel_q][wr_addr_i] = wr_data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bank_q <= '0;
            sel_q  <= 1'b0;
        end else begin
            bank_q <= bank_d;
            sel_q  <= sel_d;
        end
    end

    assign front_o = bank_q[sel_q];

endmodule

// File: rtl/charlie_scan.sv
// Charlieplexed LED matrix scanner with double-buffered frame store.
// Define CHARLIE_SCAN_PWM_EN for per-LED grayscale; otherwise LEDs are on/off.
module charlie_scan
    import charlie_pkg::*;
#(
    parameter int unsigned PINS           = 7,
    parameter int unsigned TICKS_PER_SLOT = 4800,
    parameter int unsigned DEAD_TICKS     = 2,
    parameter int unsigned PWM_BITS       = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              wr_en,
    input  logic [$clog2(PINS*(PINS-1))-1:0]  wr_addr,
    input  logic [PWM_BITS-1:0]               wr_data,
    input  logic                              swap_req,
    output logic                              swap_ack,
    output logic                              frame_start,
    output logic [PINS-1:0]                   charlie_oe,
    output logic [PINS-1:0]                   charlie_o
);

    localparam int unsigned LEDS = PINS * (PINS - 1);
    localparam int unsigned AW   = $clog2(LEDS);
`ifdef CHARLIE_SCAN_PWM_EN
    localparam int unsigned LW       = PWM_BITS;
    localparam int unsigned SUBSLOTS = (1 << PWM_BITS) - 1;
`else
    localparam int unsigned LW       = 1;
    localparam int unsigned SUBSLOTS = 1;
    logic unused_wr;
    assign unused_wr = ^wr_data;
`endif
    localparam int unsigned SW   = LW;
    localparam int unsigned RW   = $clog2(PINS);
    localparam int unsigned CMAX = (TICKS_PER_SLOT > DEAD_TICKS) ? TICKS_PER_SLOT : DEAD_TICKS;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    state_e                  state_q, state_d;
    logic [RW-1:0]           row_q, row_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SW-1:0]           sub_q, sub_d;
    logic                    pend_q, pend_d;
    logic                    row_end_c, swap_c;
    logic [PINS-1:0]         oe_d, o_d;
    logic                    fs_d, ack_d;
    logic [LEDS-1:0][LW-1:0] front_c;

    charlie_framebuf #(
        .LEDS (LEDS),
        .LW   (LW),
        .AW   (AW)
    ) u_framebuf (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data[LW-1:0]),
        .swap_i    (swap_c),
        .front_o   (front_c)
    );

    // Scan sequencing, swap arbitration and next pin levels.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cnt_d     = cnt_q + CW'(1);
        sub_d     = sub_q;
        row_end_c = 1'b0;
        oe_d      = '0;
        o_d       = '0;

        unique case (state_q)
            DEAD: begin
                if (cnt_q == CW'(DEAD_TICKS - 1)) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                    sub_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == CW'(TICKS_PER_SLOT - 1)) begin
                    cnt_d = '0;
                    if (sub_q == SW'(SUBSLOTS - 1)) begin
                        row_end_c = 1'b1;
                        state_d   = DEAD;
                        row_d     = (row_q == RW'(PINS - 1)) ? '0 : row_q + RW'(1);
                    end else begin
                        sub_d = sub_q + SW'(1);
                    end
                end
            end
            default: ;
        endcase

        swap_c = row_end_c && (row_q == RW'(PINS - 1)) && pend_q;
        pend_d = swap_req || (pend_q && !swap_c);
        fs_d   = (state_q == DEAD) && (row_q == '0) && (cnt_q == '0);
        ack_d  = swap_c;

        // Anode high; a cathode sinks only while its LED is lit in this subslot.
        if (state_q == DRIVE) begin
            oe_d[row_q] = 1'b1;
            o_d[row_q]  = 1'b1;
            for (int unsigned c = 0; c < PINS; c++) begin
                if (RW'(c) != row_q) begin
                    if (front_c[AW'(led_index(32'(row_q), c, PINS))] > sub_q) begin
                        oe_d[RW'(c)] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= DEAD;
            row_q       <= '0;
            cnt_q       <= '0;
            sub_q       <= '0;
            pend_q      <= 1'b0;
            charlie_oe  <= '0;
            charlie_o   <= '0;
            frame_start <= 1'b0;
            swap_ack    <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            sub_q       <= sub_d;
            pend_q      <= pend_d;
            charlie_oe  <= oe_d;
            charlie_o   <= o_d;
            frame_start <= fs_d;
            swap_ack    <= ack_d;
        end
    end

endmodule

// File: tb/tb_charlie_scan.sv
// Self-checking bench for charlie_scan: directed scenarios plus random traffic against a frame-level model.
module tb_charlie_scan;

    localparam int PINS   = 3;
    localparam int TICKS  = 4;
    localparam int DEAD   = 1;
    localparam int PWMB   = 2;
    localparam int LEDS   = PINS * (PINS - 1);
`ifdef CHARLIE_SCAN_PWM_EN
    localparam int SUBS   = (1 << PWMB) - 1;
    localparam int MASK   = (1 << PWMB) - 1;
    localparam logic [2:0] OE_AFTER_SLOT0 = 3'b001;
`else
    localparam int SUBS   = 1;
    localparam int MASK   = 1;
    localparam logic [2:0] OE_AFTER_SLOT0 = 3'b000;
`endif
    localparam int ROWLEN = DEAD + SUBS * TICKS;
    localparam int FRAME  = PINS * ROWLEN;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [1:0] wr_data = '0;
    logic       swap_req = 1'b0;
    logic       swap_ack, frame_start;
    logic [2:0] charlie_oe, charlie_o;

    charlie_scan #(
        .PINS           (PINS),
        .TICKS_PER_SLOT (TICKS),
        .DEAD_TICKS     (DEAD),
        .PWM_BITS       (PWMB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .frame_start (frame_start),
        .charlie_oe  (charlie_oe),
        .charlie_o   (charlie_o)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int acks     = 0;

    // Model: cycle position within the frame, both banks, pending flag, expected outputs.
    int         m_t = 0;
    int         m_front[LEDS];
    int         m_back[LEDS];
    bit         m_pend = 1'b0;
    logic [2:0] exp_oe = '0;
    logic [2:0] exp_o  = '0;
    logic       exp_fs = 1'b0;
    logic       exp_ack = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Outputs seen after an edge describe the scan position held before that edge.
    task automatic model_edge();
        int  p, row, q, k, idx, tmp;
        bit  do_swap;
        if (reset) begin
            m_t = 0;
            m_pend = 1'b0;
            for (int i = 0; i < LEDS; i++) begin
                m_front[i] = 0;
                m_back[i]  = 0;
            end
            exp_oe = '0; exp_o = '0; exp_fs = 1'b0; exp_ack = 1'b0;
        end else begin
            p   = m_t % FRAME;
            row = p / ROWLEN;
            q   = p % ROWLEN;
            exp_oe = '0;
            exp_o  = '0;
            exp_fs = (p == 0);
            if (q >= DEAD) begin
                k = (q - DEAD) / TICKS;
                exp_oe = exp_oe | 3'(1 << row);
                exp_o  = 3'(1 << row);
                for (int c = 0; c < PINS; c++) begin
                    if (c != row) begin
                        idx = row * (PINS - 1) + ((c < row) ? c : c - 1);
                        if (m_front[idx] > k) exp_oe = exp_oe | 3'(1 << c);
                    end
                end
            end
            do_swap = (p == FRAME - 1) && m_pend;
            exp_ack = do_swap;
            if (wr_en && (int'(wr_addr) < LEDS)) m_back[int'(wr_addr)] = int'(wr_data) & MASK;
            if (do_swap) begin
                for (int i = 0; i < LEDS; i++) begin
                    tmp = m_front[i];
                    m_front[i] = m_back[i];
                    m_back[i] = tmp;
                end
            end
            m_pend = swap_req || (m_pend && !do_swap);
            m_t++;
        end
    endtask

    task automatic cycle(input bit rst, input bit we, input int addr, input int data, input bit sreq);
        @(negedge clock);
        reset    = rst;
        wr_en    = we;
        wr_addr  = 3'(addr);
        wr_data  = 2'(data);
        swap_req = sreq;
        @(posedge clock);
        model_edge();
        #1;
        if (swap_ack === 1'b1) acks++;
        check_eq("oe", 32'(charlie_oe), 32'(exp_oe));
        check_eq("o", 32'(charlie_o), 32'(exp_o));
        check_eq("frame_start", 32'(frame_start), 32'(exp_fs));
        check_eq("swap_ack", 32'(swap_ack), 32'(exp_ack));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    // Advance until the next cycle to execute sits at frame position pos (bounded to one frame).
    task automatic run_to(input int pos);
        for (int i = 0; i < FRAME && (m_t % FRAME) != pos; i++) cycle(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        int a0;
        for (int i = 0; i < LEDS; i++) begin
            m_front[i] = 0;
            m_back[i]  = 0;
        end

        // Reset, then blank frames from zeroed banks.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0, 0, 1'b0);
        idle(2 * FRAME);

        // Full brightness on LED 0 after a swap.
        cycle(1'b0, 1'b1, 0, 3, 1'b1);
        run_to(0);
        idle(DEAD + 1);
        check_eq("row0_full_oe", 32'(charlie_oe), 32'(3'b011));
        check_eq("row0_full_o", 32'(charlie_o), 32'(3'b001));
        idle(FRAME);

        // Level 1: lit in the first subslot only.
        cycle(1'b0, 1'b1, 0, 1, 1'b1);
        run_to(0);
        idle(DEAD + 1);
        check_eq("row0_lvl1_oe", 32'(charlie_oe), 32'(3'b011));
        idle(TICKS);
        check_eq("row0_lvl1_late_oe", 32'(charlie_oe), 32'(OE_AFTER_SLOT0));
        idle(FRAME);

        // Out-of-range write and a doubled swap request.
        a0 = acks;
        cycle(1'b0, 1'b1, 6, 3, 1'b1);
        idle(3);
        cycle(1'b0, 1'b0, 0, 0, 1'b1);
        run_to(0);
        idle(FRAME);
        check_eq("single_ack", 32'(acks - a0), 32'd1);

        // Reset mid-DRIVE of row 1 discards the pending swap.
        cycle(1'b0, 1'b1, 2, 2, 1'b1);
        run_to(ROWLEN + DEAD + 2);
        cycle(1'b1, 1'b0, 0, 0, 1'b0);
        check_eq("reset_oe", 32'(charlie_oe), 32'd0);
        a0 = acks;
        idle(2 * FRAME);
        check_eq("no_ack_after_reset", 32'(acks - a0), 32'd0);

        // Write and new request exactly in the swap cycle.
        cycle(1'b0, 1'b0, 0, 0, 1'b1);
        run_to(FRAME - 1);
        cycle(1'b0, 1'b1, 1, 2, 1'b1);
        a0 = acks;
        idle(2 * FRAME);
        check_eq("coincident_req_ack", 32'(acks - a0), 32'd1);

        // Random traffic, including out-of-range addresses and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 299) == 0), $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/charlie_scan.md
CHARLIE_SCAN -- requirements
Module: charlie_scan

Interface
REQ-001 SHALL have parameter PINS, default 7, meaning the charlieplex pin count (LEDS = PINS*(PINS-1); minimum 2).
REQ-002 SHALL have parameter TICKS_PER_SLOT, default 4800, meaning clock cycles per drive slot (minimum 1).
REQ-003 SHALL have parameter DEAD_TICKS, default 2, meaning all-released cycles before each row (minimum 1).
REQ-004 SHALL have parameter PWM_BITS, default 4, meaning the per-LED brightness width (minimum 1).
REQ-005 SHALL have port clock, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port wr_en, input, 1 bit: writes wr_data to back-bank LED wr_addr.
REQ-008 SHALL have port wr_addr, input, $clog2(LEDS) bits: LED index.
REQ-009 SHALL have port wr_data, input, PWM_BITS bits: brightness; only bit 0 is used without the macro.
REQ-010 SHALL have port swap_req, input, 1 bit: one-cycle pulse requesting a bank swap.
REQ-011 SHALL have port swap_ack, output, 1 bit: one-cycle pulse on the cycle the swap takes effect.
REQ-012 SHALL have port frame_start, output, 1 bit: one-cycle pulse on the first DEAD cycle of row 0.
REQ-013 SHALL have port charlie_oe, output, PINS bits: per-pin output enable (0 = hi-Z).
REQ-014 SHALL have port charlie_o, output, PINS bits: per-pin output level.

Function
REQ-015 LED index SHALL be r*(PINS-1)+c', where r is the anode (row) pin, c the cathode pin (c != r), and c' = c when c<r, else c-1.
REQ-016 The FSM SHALL have two states, DEAD and DRIVE; DEAD lasts DEAD_TICKS cycles with charlie_oe=0 and charlie_o=0, then goes to DRIVE.
REQ-017 DRIVE SHALL last SUBSLOTS*TICKS_PER_SLOT cycles, then go to DEAD of row (r+1) mod PINS, wrapping PINS-1 to 0.
REQ-018 In DRIVE, pin r SHALL have oe=1, o=1; each pin c != r SHALL have oe=1, o=0 when its LED is lit in subslot k, else oe=0, o=0.
REQ-019 The LED at index i SHALL be lit in subslot k (0-based) iff front[i] > k; the subslot advances every TICKS_PER_SLOT cycles.
REQ-020 Outputs SHALL be registered: exactly one cycle from state/counter change to pin change.
REQ-021 A write with wr_addr >= LEDS SHALL be ignored; a write SHALL never modify the front bank.
REQ-022 swap_req SHALL set a pending flag; a swap_req while the flag is pending SHALL have no additional effect.
REQ-023 The swap SHALL occur on the last DRIVE cycle of row PINS-1, when pending: swap banks, clear pending, pulse swap_ack the same cycle.
REQ-024 After a swap, the new front bank SHALL first be displayed from the next frame_start.
REQ-025 A write in the swap cycle SHALL land in the pre-swap back bank, so it becomes visible.
REQ-026 swap_req coincident with the swap cycle SHALL be captured as a new pending request.
REQ-027 The new back bank SHALL retain its old front contents; no copy is made.

Reset
REQ-028 On reset the block SHALL set state DEAD, row 0, counters 0, bank select 0, pending 0, and both banks all 0.
REQ-029 On reset the block SHALL drive charlie_oe=0, charlie_o=0, swap_ack=0, frame_start=0 on the following cycle.
REQ-030 Reset asserted mid-frame SHALL take effect at the next edge, abandoning the row and any pending swap.
REQ-031 frame_start SHALL pulse on the first cycle after reset deasserts.

Configuration
REQ-032 Macro CHARLIE_SCAN_PWM_EN defined: SUBSLOTS = 2^PWM_BITS-1, with full grayscale per REQ-019.
REQ-033 CHARLIE_SCAN_PWM_EN undefined: SUBSLOTS=1, each bank stores 1 bit per LED, and an LED is lit iff that stored bit (wr_data[0]) is 1.

Structure
REQ-034 Package charlie_pkg SHALL hold the state enum (DEAD, DRIVE) and the function led_index(r,c,PINS).
REQ-035 Sub-module charlie_framebuf SHALL hold the two banks, the write port, bank select and an asynchronous read port.
REQ-036 Sub-module charlie_framebuf SHALL be instantiated once.
REQ-037 The scan FSM, counters and swap logic SHALL stay in charlie_scan.

Verification (PINS=3, TICKS_PER_SLOT=4, DEAD_TICKS=1, PWM_BITS=2, macro defined: row=13, frame=39 cycles)
REQ-038 Release reset -> charlie_oe=000 first cycle; frame_start pulses every 39 cycles; all cathodes hi-Z (banks 0).
REQ-039 Write idx0=3, swap_req -> swap_ack at end of frame; the next frame's row0 DRIVE gives oe=011, o=001 for all 12 cycles.
REQ-040 idx0=1, swap -> pin1 oe=1 for DRIVE cycles 0-3 only, then oe=001.
REQ-041 Write addr 6 (out of range) -> no bank change; two swap_req in one frame -> a single swap_ack.
REQ-042 Reset asserted mid-DRIVE of row 1 -> next cycle oe=000, the pending swap is discarded, frame_start pulses after release.
REQ-043 The bench SHALL re-run REQ-039 with the macro undefined (row=5 cycles), with wr_data=1 lit for all 4 DRIVE cycles.
